// File: rtl/rat_fetch_pkg.sv
// Purpose : shared types and constants for the RAT MCU instruction-fetch unit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, next-PC source encodings, default widths
// and the interrupt vector. Imported by the fetch interface and top.
package rat_fetch_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int IR_W_DEF      = 18;
    localparam int RAS_DEPTH_DEF = 8;
    localparam logic [ADDR_W_DEF-1:0] INTR_VEC_DEF = 10'h3FF;

    // One instruction every three cycles: present address, ROM data valid,
    // then hold the registered instruction until it is consumed.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LATCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2,
        SEL_RSVD  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/rat_fetch_unit_if.sv
// Purpose : bundles the ProgRom address/data pair and the control-unit handshake.
// Latency : n/a (wires only).
// Backpressure: IR_VALID/IR_READY handshake; the fetch side holds IR while IR_READY=0.
//
// Modports: master = fetch unit (drives PROG_ADDR, IR, IR_VALID, PC);
//           slave  = ROM + control unit side.
// With RAT_FETCH_RAS_EN defined, RAS_PUSH/RAS_POP (in) and RAS_OVF/RAS_UNF (out)
// are added for the internal return-address stack.
interface rat_fetch_unit_if
    import rat_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IR_W   = IR_W_DEF
);
    logic [ADDR_W-1:0] PROG_ADDR;
    logic [IR_W-1:0]   PROG_IR;
    logic [IR_W-1:0]   IR;
    logic              IR_VALID;
    logic              IR_READY;
    logic [ADDR_W-1:0] PC;
    logic              PC_LD;
    logic [1:0]        PC_MUX_SEL;
    logic [ADDR_W-1:0] FROM_IMMED;
    logic [ADDR_W-1:0] FROM_STACK;
    logic              INTR;
`ifdef RAT_FETCH_RAS_EN
    logic              RAS_PUSH;
    logic              RAS_POP;
    logic              RAS_OVF;
    logic              RAS_UNF;

    modport master (
        output PROG_ADDR, IR, IR_VALID, PC, RAS_OVF, RAS_UNF,
        input  PROG_IR, IR_READY, PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INTR,
               RAS_PUSH, RAS_POP
    );

    modport slave (
        input  PROG_ADDR, IR, IR_VALID, PC, RAS_OVF, RAS_UNF,
        output PROG_IR, IR_READY, PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INTR,
               RAS_PUSH, RAS_POP
    );
`else
    modport master (
        output PROG_ADDR, IR, IR_VALID, PC,
        input  PROG_IR, IR_READY, PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INTR
    );

    modport slave (
        input  PROG_ADDR, IR, IR_VALID, PC,
        output PROG_IR, IR_READY, PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INTR
    );
`endif

endinterface

// File: rtl/rat_return_stack.sv
// Purpose : circular return-address LIFO with sticky overflow/underflow flags.
// Latency : top_dat is combinational from state; push/pop take effect at the CLK edge.
// Backpressure: none; push when full silently drops the oldest entry (RAS_OVF),
//               pop when empty returns 0 (RAS_UNF).
//
// Ports: CLK/RST, push/pop strobes (already qualified by the caller),
//        push_dat, top_dat (0 when empty), ovf/unf sticky flags.
// Only built when RAT_FETCH_RAS_EN is defined.
module rat_return_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top_dat,
    output logic              ovf,
    output logic              unf
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr;     // next free slot; wraps onto the oldest entry
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  top_idx;
    logic              empty;
    logic              full;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;

    assign ptr_inc = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
    assign top_idx = (wr_ptr == '0) ? PTR_MAX : wr_ptr - 1'b1;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);
    assign top_dat = empty ? '0 : mem[top_idx];

    // Push writes the free slot; push+pop overwrites the current top in place.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        if (push && !pop) begin
            mem_we    = 1'b1;
            mem_waddr = wr_ptr;
        end else if (push && pop && !empty) begin
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= push_dat;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    wr_ptr <= ptr_inc;
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                2'b01: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end else begin
                        wr_ptr <= top_idx;
                        cnt    <= cnt - 1'b1;
                    end
                end
                2'b11: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rat_fetch_unit.sv
// Purpose : RAT MCU instruction fetch: owns the PC, drives ProgRom, registers IR.
// Latency : 2 edges from PROG_ADDR change to IR_VALID; 1 instruction per 3 cycles.
// Backpressure: IR/PC/PROG_ADDR held bit-stable in HOLD until IR_VALID && IR_READY.
//
// Ports: CLK, RST (async, active-high), bus (rat_fetch_unit_if.master):
//   PROG_ADDR/PROG_IR to ProgRom, IR/IR_VALID/IR_READY/PC to the control unit,
//   PC_LD/PC_MUX_SEL/FROM_IMMED/FROM_STACK/INTR select the next PC at accept.
// Option RAT_FETCH_RAS_EN: internal return-address stack (rat_return_stack)
//   driven by RAS_PUSH/RAS_POP; a pop redirects SEL_STACK to the popped entry.
module rat_fetch_unit
    import rat_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                IR_W     = IR_W_DEF,
    parameter logic [ADDR_W-1:0] INTR_VEC = INTR_VEC_DEF
`ifdef RAT_FETCH_RAS_EN
  , parameter int                RAS_DEPTH = RAS_DEPTH_DEF
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    rat_fetch_unit_if.master bus
);
    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] prog_addr_q;
    logic [IR_W-1:0]   ir_q;
    logic              ir_valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stack_src;
    logic [ADDR_W-1:0] next_pc;
    logic              accept;

    // IR_VALID is only ever set in HOLD, so READY outside HOLD is inert.
    assign accept = ir_valid_q && bus.IR_READY;
    assign pc_inc = pc_q + 1'b1;

`ifdef RAT_FETCH_RAS_EN
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push_en;
    logic              ras_pop_en;

    assign ras_push_en = accept && bus.RAS_PUSH;
    assign ras_pop_en  = accept && bus.RAS_POP;

    rat_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .CLK      (CLK),
        .RST      (RST),
        .push     (ras_push_en),
        .pop      (ras_pop_en),
        .push_dat (pc_inc),
        .top_dat  (ras_top),
        .ovf      (bus.RAS_OVF),
        .unf      (bus.RAS_UNF)
    );

    // ras_top is the pre-edge top, i.e. the entry being popped this edge.
    assign stack_src = bus.RAS_POP ? ras_top : bus.FROM_STACK;
`else
    assign stack_src = bus.FROM_STACK;
`endif

    // Priority: interrupt, then explicit load, then sequential (wraps naturally).
    always_comb begin
        next_pc = pc_inc;
        if (bus.INTR) begin
            next_pc = INTR_VEC;
        end else if (bus.PC_LD) begin
            case (pc_sel_t'(bus.PC_MUX_SEL))
                SEL_IMMED: next_pc = bus.FROM_IMMED;
                SEL_STACK: next_pc = stack_src;
                SEL_INTR:  next_pc = INTR_VEC;
                default:   next_pc = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = LATCH;
            LATCH:   state_d = HOLD;
            HOLD:    state_d = accept ? FETCH : HOLD;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prog_addr_q <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            pc_q        <= '0;
        end else begin
            if (state_q == LATCH) begin
                ir_q       <= bus.PROG_IR;
                pc_q       <= prog_addr_q;
                ir_valid_q <= 1'b1;
            end
            if (state_q == HOLD && accept) begin
                ir_valid_q  <= 1'b0;
                prog_addr_q <= next_pc;
            end
        end
    end

    assign bus.PROG_ADDR = prog_addr_q;
    assign bus.IR        = ir_q;
    assign bus.IR_VALID  = ir_valid_q;
    assign bus.PC        = pc_q;

endmodule
